// File: rtl/backprop_neuron_if.sv
// Layer-controller side bus of one backprop_neuron: weight register port,
// pass control, activation input stream and back-error output stream.
interface backprop_neuron_if #(
   parameter int N_INPUTS = 4,
   parameter int IDX_W    = $clog2(N_INPUTS)
);
   logic                    wr_en;
   logic [IDX_W-1:0]        wr_addr;
   logic signed [7:0]       wr_data;
   logic [IDX_W-1:0]        rd_addr;
   logic signed [7:0]       rd_data;
   logic                    start;
   logic signed [7:0]       delta;
   logic [2:0]              lr_shift;
   logic                    in_valid;
   logic signed [7:0]       in_x;
   logic                    in_ready;
   logic                    out_valid;
   logic signed [7:0]       out_err;
   logic [IDX_W-1:0]        out_idx;
   logic                    out_ready;
   logic                    busy;
   logic                    done;

   modport master (
      output wr_en, wr_addr, wr_data, rd_addr, start, delta, lr_shift,
             in_valid, in_x, out_ready,
      input  rd_data, in_ready, out_valid, out_err, out_idx, busy, done
   );

   modport slave (
      input  wr_en, wr_addr, wr_data, rd_addr, start, delta, lr_shift,
             in_valid, in_x, out_ready,
      output rd_data, in_ready, out_valid, out_err, out_idx, busy, done
   );
endinterface

// File: rtl/backprop_neuron.sv
// Backward pass of one neuron: streams sat(w_i*delta) back to the previous
// layer and applies the SGD step w_i -= (delta*x_i) >>> lr_shift in place.
//
// state | meaning
// IDLE  | weight writes accepted, waiting for start
// RUN   | one activation per handshake, emits back-error, updates weight
// DONE  | one-cycle done pulse, returns to IDLE
module backprop_neuron #(
   parameter int N_INPUTS = 4,
   parameter int IDX_W    = $clog2(N_INPUTS)
) (
   input logic                clk,
   input logic                reset,
   backprop_neuron_if.slave   bus
);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_INPUTS - 1);

   state_t              state_q;
   logic signed [7:0]   w_q [N_INPUTS];
   logic [IDX_W-1:0]    idx_q;
   logic signed [7:0]   delta_q;
   logic [2:0]          lr_q;
   logic                out_valid_q;
   logic signed [7:0]   out_err_q;
   logic [IDX_W-1:0]    out_idx_q;
   logic                busy_q;
   logic                done_q;

   function automatic logic signed [7:0] sat8(input logic signed [15:0] v);
      if (v > 16'sd127)
         return 8'sd127;
      else if (v < -16'sd128)
         return 8'h80;
      else
         return v[7:0];
   endfunction

   logic signed [7:0]   w_cur;
   logic signed [15:0]  err_prod;
   logic signed [15:0]  grad_prod;
   logic signed [15:0]  grad_sh;
   logic signed [11:0]  w_diff;
   logic signed [7:0]   err_d;
   logic signed [7:0]   w_d;
   logic                hs;

   assign w_cur     = w_q[idx_q];
   assign err_prod  = w_cur * delta_q;
   assign grad_prod = delta_q * bus.in_x;
   // grad magnitude never exceeds 512, so the 12-bit difference cannot wrap
   assign grad_sh   = (grad_prod >>> 5) >>> lr_q;
   assign w_diff    = 12'(w_cur) - 12'(grad_sh);
   assign err_d     = sat8(err_prod >>> 5);
   assign w_d       = sat8(16'(w_diff));

   assign bus.in_ready  = (state_q == RUN) && (!out_valid_q || bus.out_ready);
   assign hs            = bus.in_valid && bus.in_ready;
   assign bus.rd_data   = w_q[bus.rd_addr];
   assign bus.out_valid = out_valid_q;
   assign bus.out_err   = out_err_q;
   assign bus.out_idx   = out_idx_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         for (int i = 0; i < N_INPUTS; i++) w_q[i] <= '0;
         idx_q       <= '0;
         delta_q     <= '0;
         lr_q        <= '0;
         out_valid_q <= 1'b0;
         out_err_q   <= '0;
         out_idx_q   <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         done_q <= 1'b0;
         // a pending output may drain in any state, including after done
         if (out_valid_q && bus.out_ready) out_valid_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (bus.wr_en) w_q[bus.wr_addr] <= bus.wr_data;
               if (bus.start) begin
                  delta_q <= bus.delta;
                  lr_q    <= bus.lr_shift;
                  idx_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= RUN;
               end
            end
            RUN: begin
               if (hs) begin
                  out_err_q   <= err_d;
                  out_idx_q   <= idx_q;
                  out_valid_q <= 1'b1;
                  w_q[idx_q]  <= w_d;
                  idx_q       <= idx_q + IDX_W'(1);
                  if (idx_q == LAST_IDX) begin
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                     state_q <= DONE;
                  end
               end
            end
            DONE: state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_backprop_neuron.sv
// Directed and randomized backward passes checked against an integer model
// of the neuron's weights and back-error stream.
module tb_backprop_neuron;
   localparam int N = 4;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   backprop_neuron_if #(.N_INPUTS(N)) bus ();
   backprop_neuron #(.N_INPUTS(N)) dut (.clk(clk), .reset(reset), .bus(bus));

   int checks = 0;
   int failures = 0;
   int m_w [N];
   logic [7:0] xs [N];

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic int sx(input logic [7:0] b);
      return int'($signed(b));
   endfunction

   function automatic int sat8(input int v);
      return (v > 127) ? 127 : ((v < -128) ? -128 : v);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.wr_en = 0; bus.wr_addr = '0; bus.wr_data = '0; bus.rd_addr = '0;
      bus.start = 0; bus.delta = '0; bus.lr_shift = '0;
      bus.in_valid = 0; bus.in_x = '0; bus.out_ready = 0;
   endtask

   task automatic wr(input int a, input logic [7:0] d);
      bus.wr_en = 1; bus.wr_addr = 2'(a); bus.wr_data = d;
      tick();
      bus.wr_en = 0;
      m_w[a] = sx(d);
   endtask

   task automatic check_weights(input string tag);
      for (int i = 0; i < N; i++) begin
         bus.rd_addr = 2'(i);
         #1;
         chk(tag, bus.rd_data, 8'(m_w[i]));
      end
   endtask

   // mode 0: free flow, 1: random stalls, 2: 5-cycle output stall, 3: ignored commands
   task automatic run_pass(input logic [7:0] d, input logic [2:0] lr, input int mode,
                           input bit co_wr, input int co_a, input logic [7:0] co_d);
      int exp_err [N];
      int sent = 0, got = 0, it = 0, done_cnt = 0;
      bit ov = 0, last_hs = 0, hs, acc;
      bus.start = 1; bus.delta = d; bus.lr_shift = lr;
      if (co_wr) begin
         bus.wr_en = 1; bus.wr_addr = 2'(co_a); bus.wr_data = co_d;
         m_w[co_a] = sx(co_d);
      end
      for (int i = 0; i < N; i++) begin
         exp_err[i] = sat8((m_w[i] * sx(d)) >>> 5);
         m_w[i] = sat8(m_w[i] - (((sx(d) * sx(xs[i])) >>> 5) >>> lr));
      end
      tick();
      bus.start = 0; bus.wr_en = 0;
      while (got < N && it < 200) begin
         bus.start = 0; bus.wr_en = 0;
         bus.in_valid = (sent < N) && (mode != 1 || $urandom_range(0, 3) != 0);
         bus.in_x = xs[(sent < N) ? sent : 0];
         case (mode)
            1:       bus.out_ready = ($urandom_range(0, 2) != 0);
            2:       bus.out_ready = !(it >= 1 && it <= 5);
            default: bus.out_ready = 1;
         endcase
         if (mode == 3 && it == 1) begin
            bus.start = 1; bus.delta = 8'h7F;
            bus.wr_en = 1; bus.wr_addr = '0; bus.wr_data = 8'h55;
         end
         #1;
         chk("busy", 8'(bus.busy), 8'(sent < N));
         chk("done", 8'(bus.done), 8'(last_hs));
         if (last_hs) done_cnt++;
         chk("out_valid", 8'(bus.out_valid), 8'(ov));
         chk("in_ready", 8'(bus.in_ready), 8'((sent < N) && (!ov || bus.out_ready)));
         if (ov) begin
            chk("out_err", bus.out_err, 8'(exp_err[got]));
            chk("out_idx", 8'(bus.out_idx), 8'(got));
         end
         hs = bus.in_valid && (sent < N) && (!ov || bus.out_ready);
         acc = ov && bus.out_ready;
         if (acc) got++;
         last_hs = hs && (sent == N - 1);
         if (hs) sent++;
         ov = hs || (ov && !bus.out_ready);
         tick();
         it++;
      end
      bus.in_valid = 0; bus.start = 0; bus.wr_en = 0;
      #1;
      chk("pass_complete", 8'(got), 8'(N));
      chk("done_end", 8'(bus.done), 8'(last_hs));
      if (last_hs) done_cnt++;
      chk("done_pulses", 8'(done_cnt), 8'd1);
      chk("out_valid_end", 8'(bus.out_valid), 8'(ov));
      chk("busy_end", 8'(bus.busy), 8'd0);
      if (mode == 0) chk("throughput", 8'(it), 8'(N + 1));
      tick();
      check_weights("weights");
   endtask

   initial begin
      idle_inputs();
      reset = 1;
      repeat (3) tick();
      reset = 0;
      for (int i = 0; i < N; i++) m_w[i] = 0;
      chk("rst_busy", 8'(bus.busy), 8'd0);
      chk("rst_done", 8'(bus.done), 8'd0);
      chk("rst_out_valid", 8'(bus.out_valid), 8'd0);
      chk("rst_out_err", bus.out_err, 8'd0);
      chk("rst_out_idx", 8'(bus.out_idx), 8'd0);
      chk("rst_in_ready", 8'(bus.in_ready), 8'd0);
      check_weights("rst_weights");

      // basic update
      for (int i = 0; i < N; i++) wr(i, 8'h20);
      xs = '{8'h10, 8'h10, 8'h10, 8'h10};
      run_pass(8'h20, 3'd0, 0, 0, 0, 8'h00);
      bus.rd_addr = 2'd2; #1;
      chk("basic_w2", bus.rd_data, 8'h10);

      // learning-rate shift
      for (int i = 0; i < N; i++) wr(i, 8'h20);
      run_pass(8'h20, 3'd2, 0, 0, 0, 8'h00);
      bus.rd_addr = 2'd1; #1;
      chk("lr_w1", bus.rd_data, 8'h1C);

      // saturation, both directions
      wr(0, 8'h80);
      xs = '{8'h7F, 8'h10, 8'hF0, 8'h01};
      run_pass(8'h80, 3'd0, 0, 0, 0, 8'h00);
      bus.rd_addr = 2'd0; #1;
      chk("sat_w0", bus.rd_data, 8'h7F);
      wr(1, 8'h7F);
      xs = '{8'h01, 8'h7F, 8'h02, 8'h03};
      run_pass(8'h7F, 3'd0, 0, 0, 0, 8'h00);
      bus.rd_addr = 2'd1; #1;
      chk("sat_w1", bus.rd_data, 8'h80);

      // backpressure and ignored commands
      for (int i = 0; i < N; i++) wr(i, 8'(8'h10 + 8'(i * 8)));
      xs = '{8'h20, 8'hE0, 8'h05, 8'h40};
      run_pass(8'h30, 3'd1, 2, 0, 0, 8'h00);
      run_pass(8'hD0, 3'd0, 3, 0, 0, 8'h00);

      // reset in the middle of a pass
      for (int i = 0; i < N; i++) wr(i, 8'h33);
      bus.start = 1; bus.delta = 8'h20; bus.lr_shift = 3'd0;
      tick();
      bus.start = 0;
      bus.in_valid = 1; bus.in_x = 8'h10; bus.out_ready = 1;
      repeat (2) tick();
      bus.in_valid = 0;
      reset = 1;
      tick();
      reset = 0;
      for (int i = 0; i < N; i++) m_w[i] = 0;
      chk("midrst_busy", 8'(bus.busy), 8'd0);
      chk("midrst_out_valid", 8'(bus.out_valid), 8'd0);
      check_weights("midrst_weights");
      xs = '{8'h11, 8'h22, 8'hC0, 8'h7F};
      run_pass(8'h40, 3'd0, 0, 0, 0, 8'h00);

      // randomized passes, some with a write landing on the start cycle
      for (int r = 0; r < 8; r++) begin
         for (int i = 0; i < N; i++) begin
            wr(i, 8'($urandom));
            xs[i] = 8'($urandom);
         end
         run_pass(8'($urandom), 3'($urandom_range(0, 7)), (r < 4) ? 1 : 0,
                  r[0], int'($urandom_range(0, N - 1)), 8'($urandom));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
